// File: rtl/axis_frame_packer.sv
// axis_frame_packer: groups an unframed AXI-Stream beat stream into packets.
// A packet closes when it reaches MAX_LEN beats, on a flush pulse, after TIMEOUT
// idle cycles, or when the destination changes. Each packet is tagged with a
// sequence number on tuser. The core is a single hold register feeding a
// single output register.
module axis_frame_packer #(
  parameter int TDATA_WIDTH = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int TID_WIDTH   = 8,
  parameter int TUSER_WIDTH = 8,
  parameter int SOURCE_ID   = 0,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   resn,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   flush,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [TID_WIDTH-1:0]   m_axis_tid,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [15:0]            pkt_count
);

  localparam logic [7:0]  LP_MAX_LEN = 8'(MAX_LEN);
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  typedef enum logic {ST_EMPTY, ST_HELD} state_t;

  state_t                 r_state;
  state_t                 w_stateNext;

  logic [TDATA_WIDTH-1:0] r_holdData;
  logic [TDEST_WIDTH-1:0] r_holdDest;
  logic [7:0]             r_holdIdx;
  logic [15:0]            r_tmoCnt;
  logic                   r_flushPend;

  logic [TDATA_WIDTH-1:0] r_outData;
  logic [TDEST_WIDTH-1:0] r_outDest;
  logic [TUSER_WIDTH-1:0] r_outUser;
  logic                   r_outValid;
  logic                   r_outLast;
  logic [TUSER_WIDTH-1:0] r_seq;
  logic [15:0]            r_pktCount;

  logic                   w_outFree;
  logic                   w_sReady;
  logic                   w_inHs;
  logic                   w_flushReq;
  logic                   w_close;
  logic                   w_move;
  logic                   w_lastHs;
  logic [TUSER_WIDTH-1:0] w_seqNext;

  // State register: EMPTY means nothing held, HELD means one beat waits in hold.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) r_state <= ST_EMPTY;
    else       r_state <= w_stateNext;
  end

  // Next state: a beat in EMPTY is captured; in HELD we drain to EMPTY only when the held beat leaves with no replacement.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_EMPTY: if (w_inHs) w_stateNext = ST_HELD;
      ST_HELD:  if (w_move && !w_inHs) w_stateNext = ST_EMPTY;
      default:  w_stateNext = ST_EMPTY;
    endcase
  end

  // Handshake, close and move decisions; the tuser for a moved beat already accounts for a packet finishing this cycle.
  always_comb begin
    w_outFree  = !r_outValid || m_axis_tready;
    w_sReady   = (r_state == ST_EMPTY) || w_outFree;
    w_inHs     = s_axis_tvalid && w_sReady;
    w_flushReq = flush || r_flushPend;
    w_close    = (r_state == ST_HELD) &&
                 ((r_holdIdx == LP_MAX_LEN) || w_flushReq || (r_tmoCnt == LP_TIMEOUT) ||
                  (w_inHs && (s_axis_tdest != r_holdDest)));
    w_move     = (r_state == ST_HELD) && w_outFree && (w_inHs || w_close);
    w_lastHs   = r_outValid && m_axis_tready && r_outLast;
    w_seqNext  = r_seq + TUSER_WIDTH'(w_lastHs);
  end

  // Hold register, idle timer and latched flush for the beat waiting to be emitted.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_holdData  <= '0;
      r_holdDest  <= '0;
      r_holdIdx   <= '0;
      r_tmoCnt    <= '0;
      r_flushPend <= 1'b0;
    end else begin
      if (w_inHs) begin
        r_holdData <= s_axis_tdata;
        r_holdDest <= s_axis_tdest;
        r_holdIdx  <= ((r_state == ST_EMPTY) || w_close) ? 8'd1 : r_holdIdx + 8'd1;
      end
      if (w_inHs || (w_stateNext == ST_EMPTY))
        r_tmoCnt <= '0;
      else if ((r_state == ST_HELD) && (r_tmoCnt != LP_TIMEOUT))
        r_tmoCnt <= r_tmoCnt + 16'd1;
      if (w_move)
        r_flushPend <= 1'b0;
      else if ((r_state == ST_HELD) && flush)
        r_flushPend <= 1'b1;
    end
  end

  // Output register: loads on a move and otherwise holds its fields until the consumer takes the beat.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_outData  <= '0;
      r_outDest  <= '0;
      r_outUser  <= '0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
    end else if (w_move) begin
      r_outData  <= r_holdData;
      r_outDest  <= r_holdDest;
      r_outUser  <= w_seqNext;
      r_outValid <= 1'b1;
      r_outLast  <= w_close;
    end else if (m_axis_tready) begin
      r_outValid <= 1'b0;
    end
  end

  // Sequence number and completed-packet count advance when a last beat is accepted downstream.
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      r_seq      <= '0;
      r_pktCount <= '0;
    end else begin
      r_seq <= w_seqNext;
      if (w_lastHs) r_pktCount <= r_pktCount + 16'd1;
    end
  end

  assign s_axis_tready = w_sReady;
  assign m_axis_tdata  = r_outData;
  assign m_axis_tdest  = r_outDest;
  assign m_axis_tid    = TID_WIDTH'(SOURCE_ID);
  assign m_axis_tuser  = r_outUser;
  assign m_axis_tvalid = r_outValid;
  assign m_axis_tlast  = r_outLast;
  assign pkt_count     = r_pktCount;

endmodule
